// File: rtl/up_counter_ctrl_if.sv
// rtl/up_counter_ctrl_if.sv - command/status bundle between the run controller and its surroundings.
// master: command source + counter datapath side; slave: up_counter_ctrl.
interface up_counter_ctrl_if #(
  parameter int W = 4
);
  logic         start;
  logic         stop;
  logic         pause;
  logic         resume;
  logic         one_shot;
  logic [W-1:0] term_val;
  logic [W-1:0] cnt_val;
  logic         cnt_en;
  logic         cnt_clr;
  logic         wrap;
  logic         done;
  logic         busy;
  logic [7:0]   wrap_cnt;

  modport master (
    output start, stop, pause, resume, one_shot, term_val, cnt_val,
    input  cnt_en, cnt_clr, wrap, done, busy, wrap_cnt
  );

  modport slave (
    input  start, stop, pause, resume, one_shot, term_val, cnt_val,
    output cnt_en, cnt_clr, wrap, done, busy, wrap_cnt
  );
endinterface

// File: rtl/up_counter_ctrl.sv
// rtl/up_counter_ctrl.sv - run controller (clear/count/pause/wrap) for an external W-bit up-counter.
// Optional tick prescaler enabled by defining CNT_CTRL_PRESCALE_EN.
module up_counter_ctrl #(
  parameter int W        = 4,
  parameter int PRESCALE = 4
) (
  input logic               clk,
  input logic               reset,
  up_counter_ctrl_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   r_state;
  logic [W-1:0] r_term;
  logic         r_one_shot;
  logic [7:0]   r_wrap_cnt;
  logic         w_run;
  logic         w_tick;
  logic         w_hit;

  assign w_run = (r_state == S_RUN);

`ifdef CNT_CTRL_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] r_pre;

  assign w_tick = w_run && (r_pre == PW'(PRESCALE - 1));

  // Holds through PAUSE so a resumed run keeps its partial tick period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (w_run) begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
    end else if (r_state != S_PAUSE) begin
      r_pre <= '0;
    end
  end
`else
  assign w_tick = w_run;
`endif

  assign w_hit = w_tick && (bus.cnt_val == r_term);

  assign bus.cnt_en   = w_tick && !w_hit;
  assign bus.cnt_clr  = (r_state == S_IDLE) || w_hit;
  assign bus.wrap     = w_hit;
  assign bus.done     = (r_state == S_DONE);
  assign bus.busy     = w_run || (r_state == S_PAUSE);
  assign bus.wrap_cnt = r_wrap_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_term     <= '0;
      r_one_shot <= 1'b0;
      r_wrap_cnt <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.stop) begin
            r_state    <= S_IDLE;
            r_wrap_cnt <= 8'd0;
          end else if (bus.start) begin
            r_state    <= S_RUN;
            r_term     <= bus.term_val;
            r_one_shot <= bus.one_shot;
            r_wrap_cnt <= 8'd0;
          end
        end
        S_RUN: begin
          if (w_hit && r_wrap_cnt != 8'hFF) begin
            r_wrap_cnt <= r_wrap_cnt + 8'd1;
          end
          // A periodic wrap coinciding with pause still clears the counter.
          if (bus.stop) begin
            r_state    <= S_IDLE;
            r_wrap_cnt <= 8'd0;
          end else if (w_hit && r_one_shot) begin
            r_state <= S_DONE;
          end else if (bus.pause) begin
            r_state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (bus.stop) begin
            r_state    <= S_IDLE;
            r_wrap_cnt <= 8'd0;
          end else if (bus.resume) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_up_counter_ctrl.sv
// tb/tb_up_counter_ctrl.sv - scoreboard bench for up_counter_ctrl with an external counter model.
module tb_up_counter_ctrl;
  localparam int PS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cnt = 4'd0;

  up_counter_ctrl_if #(.W(4)) bus ();

  up_counter_ctrl #(.W(4), .PRESCALE(PS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.cnt_val = cnt;
  always_ff @(posedge clk) begin
    if (bus.cnt_clr) cnt <= 4'd0;
    else if (bus.cnt_en) cnt <= cnt + 4'd1;
  end

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       wrap;
    logic       done;
    logic       busy;
    logic [7:0] wc;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state, valid for the cycle currently presented.
  string      phase = "idle";
  logic [3:0] m_cnt = 4'd0;
  logic [3:0] m_term = 4'd0;
  bit         m_os = 1'b0;
  int         m_wraps = 0;
  int         m_ps = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input bit rst, input bit st, input bit sp, input bit pa,
                     input bit re, input bit os, input logic [3:0] tv);
    exp_t e;
    bit   run, tick, hit;
    @(negedge clk);
    reset = rst; bus.start = st; bus.stop = sp; bus.pause = pa;
    bus.resume = re; bus.one_shot = os; bus.term_val = tv;
    run = (phase == "run");
`ifdef CNT_CTRL_PRESCALE_EN
    tick = run && (m_ps == PS - 1);
`else
    tick = run;
`endif
    hit    = tick && (m_cnt == m_term);
    e.en   = tick && !hit;
    e.clr  = (phase == "idle") || hit;
    e.wrap = hit;
    e.done = (phase == "done");
    e.busy = run || (phase == "pause");
    e.wc   = 8'(m_wraps);
    e.cnt  = m_cnt;
    q.push_back(e);

    if (e.clr) m_cnt = 4'd0;
    else if (e.en) m_cnt = m_cnt + 4'd1;

    if (!rst) begin
      phase = "idle"; m_term = 4'd0; m_os = 1'b0; m_wraps = 0; m_ps = 0;
    end else begin
      if (run) m_ps = tick ? 0 : m_ps + 1;
      else if (phase != "pause") m_ps = 0;
      if (phase == "idle" || phase == "done") begin
        if (sp) begin
          phase = "idle"; m_wraps = 0;
        end else if (st) begin
          phase = "run"; m_term = tv; m_os = os; m_wraps = 0;
        end
      end else if (run) begin
        if (hit && m_wraps < 255) m_wraps++;
        if (sp) begin
          phase = "idle"; m_wraps = 0;
        end else if (hit && m_os) phase = "done";
        else if (pa) phase = "pause";
      end else begin
        if (sp) begin
          phase = "idle"; m_wraps = 0;
        end else if (re) phase = "run";
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 4'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("cnt_en", int'(bus.cnt_en), int'(e.en));
        chk("cnt_clr", int'(bus.cnt_clr), int'(e.clr));
        chk("wrap", int'(bus.wrap), int'(e.wrap));
        chk("done", int'(bus.done), int'(e.done));
        chk("busy", int'(bus.busy), int'(e.busy));
        chk("wrap_cnt", int'(bus.wrap_cnt), int'(e.wc));
        chk("cnt_val", int'(cnt), int'(e.cnt));
      end
    end
  end

  initial begin : driver
    bit found;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.resume = 0;
    bus.one_shot = 0; bus.term_val = 4'd0;
    @(posedge clk);
    @(posedge clk);
    cyc(0, 0, 0, 0, 0, 0, 4'd0);
    cyc(0, 1, 0, 0, 0, 0, 4'd9);
    idle_cycles(2);

    cyc(1, 1, 0, 0, 0, 0, 4'd5);
    idle_cycles(20);
    cyc(1, 1, 0, 0, 0, 1, 4'd1);
    idle_cycles(2);
    cyc(1, 0, 1, 0, 0, 0, 4'd0);

    cyc(1, 1, 0, 0, 0, 1, 4'd3);
    idle_cycles(8);
    cyc(1, 1, 0, 0, 0, 1, 4'd2);
    idle_cycles(6);

    cyc(1, 1, 0, 0, 0, 0, 4'd7);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt == 4'd4) found = 1;
      else cyc(1, 0, 0, 0, 0, 0, 4'd0);
    end
    chk("reach_cnt4", int'(found), 1);
    cyc(1, 0, 0, 1, 0, 0, 4'd0);
    idle_cycles(10);
    cyc(1, 0, 0, 1, 1, 0, 4'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cnt == 4'd7) found = 1;
      else cyc(1, 0, 0, 0, 0, 0, 4'd0);
    end
    chk("reach_cnt7", int'(found), 1);
    cyc(1, 0, 0, 1, 0, 0, 4'd0);
    idle_cycles(4);
    cyc(1, 0, 0, 0, 1, 0, 4'd0);
    idle_cycles(2);
    cyc(1, 0, 1, 0, 0, 0, 4'd0);
    cyc(1, 1, 1, 0, 0, 0, 4'd4);
    idle_cycles(3);

    cyc(1, 1, 0, 0, 0, 0, 4'd0);
    idle_cycles(300);
    cyc(1, 0, 1, 0, 0, 0, 4'd0);
    idle_cycles(2);

    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 299) != 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 4) == 0,
          1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    #4;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
